// File: rtl/fabric_port_arbiter_pkg.sv
// fabric_port_arbiter_pkg: OCP command/response codes shared by the fabric port arbiter and its picker
package fabric_port_arbiter_pkg;
  localparam logic [2:0] MCMD_IDLE = 3'd0;
  localparam logic [2:0] MCMD_WR = 3'd1;
  localparam logic [2:0] MCMD_RD = 3'd2;
  localparam logic [1:0] SRESP_NULL = 2'd0;
  localparam logic [1:0] SRESP_DVA = 2'd1;
  localparam logic [1:0] SRESP_ERR = 2'd3;
endpackage

// File: rtl/fabric_port_arbiter_rr_picker.sv
// fabric_rr_picker: combinational round-robin pick of the first requester after i_last
// Ports: i_req request vector, i_last previous owner index, o_grant one-hot pick, o_idx its index.
module fabric_rr_picker #(
  parameter int NPORTS = 2,
  localparam int IW = $clog2(NPORTS)
) (
  input  logic [NPORTS-1:0] i_req,
  input  logic [IW-1:0]     i_last,
  output logic [NPORTS-1:0] o_grant,
  output logic [IW-1:0]     o_idx
);
  // Scan from farthest to nearest so the nearest requester after i_last overwrites the rest.
  always_comb begin
    int k;
    k = 0;
    o_grant = '0;
    o_idx = '0;
    for (int i = NPORTS; i >= 1; i--) begin
      k = (int'(i_last) + i) % NPORTS;
      if (i_req[k]) begin
        o_grant = NPORTS'(1) << k;
        o_idx = IW'(k);
      end
    end
  end
endmodule

// File: rtl/fabric_port_arbiter.sv
// fabric_port_arbiter: round-robin N-master to 1-slave OCP port, grant held from command to response
// Ports: i_M_* / o_M_* packed per-master OCP buses (master k at slice k), o_P_* / i_P_* slave port,
//   o_grant one-hot owner, o_timeout watchdog pulse.
// Optional watchdog enabled by defining FABRIC_ARB_TIMEOUT_EN; otherwise o_timeout is tied low.
module fabric_port_arbiter
  import fabric_port_arbiter_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BEN_WIDTH = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NPORTS*ADDR_WIDTH-1:0]   i_M_MAddr,
  input  logic [NPORTS*3-1:0]            i_M_MCmd,
  input  logic [NPORTS*DATA_WIDTH-1:0]   i_M_MData,
  input  logic [NPORTS*BEN_WIDTH-1:0]    i_M_MByteEn,
  output logic [NPORTS-1:0]              o_M_SCmdAccept,
  output logic [NPORTS*DATA_WIDTH-1:0]   o_M_SData,
  output logic [NPORTS*2-1:0]            o_M_SResp,
  output logic [ADDR_WIDTH-1:0]          o_P_MAddr,
  output logic [2:0]                     o_P_MCmd,
  output logic [DATA_WIDTH-1:0]          o_P_MData,
  output logic [BEN_WIDTH-1:0]           o_P_MByteEn,
  input  logic                           i_P_SCmdAccept,
  input  logic [DATA_WIDTH-1:0]          i_P_SData,
  input  logic [1:0]                     i_P_SResp,
  output logic [NPORTS-1:0]              o_grant,
  output logic                           o_timeout
);
  localparam int IW = $clog2(NPORTS);
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RESP} state_e;
  state_e state_q, state_d;
  logic [NPORTS-1:0] grant_q, grant_d, req, pick;
  logic [IW-1:0] gidx_q, gidx_d, last_q, last_d, pick_idx;
  logic expire, done;
  if (NPORTS < 2 || NPORTS > 8 || TIMEOUT < 1) begin : g_param_check
    $error("fabric_port_arbiter: NPORTS must be 2..8 and TIMEOUT >= 1");
  end
  for (genvar k = 0; k < NPORTS; k++) begin : g_req
    assign req[k] = i_M_MCmd[k*3 +: 3] != MCMD_IDLE;
  end
  fabric_rr_picker #(.NPORTS(NPORTS)) u_pick (
    .i_req  (req),
    .i_last (last_q),
    .o_grant(pick),
    .o_idx  (pick_idx)
  );
`ifdef FABRIC_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;
  // A genuine slave response in the expiry cycle wins over the watchdog.
  assign expire = state_q != S_IDLE && wd_q == WW'(TIMEOUT - 1) &&
                  !(state_q == S_RESP && i_P_SResp != SRESP_NULL);
  assign wd_d = (state_q == S_IDLE || state_d != state_q) ? '0 : wd_q + 1'b1;
  always_ff @(posedge clk) wd_q <= rst ? '0 : wd_d;
`else
  assign expire = 1'b0;
`endif
  assign done = expire || (state_q == S_RESP && i_P_SResp != SRESP_NULL);
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d = gidx_q;
    last_d = last_q;
    if (state_q == S_IDLE && |req) begin
      state_d = S_CMD;
      grant_d = pick;
      gidx_d = pick_idx;
    end else if (state_q != S_IDLE && done) begin
      state_d = S_IDLE;
      grant_d = '0;
      last_d = gidx_q;
    end else if (state_q == S_CMD && i_P_SCmdAccept) begin
      state_d = S_RESP;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q <= '0;
      last_q <= IW'(NPORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q <= gidx_d;
      last_q <= last_d;
    end
  end
  // Outputs are forced quiet while rst is high so an abandoned transfer never leaks out.
  always_comb begin
    o_P_MAddr = '0;
    o_P_MCmd = MCMD_IDLE;
    o_P_MData = '0;
    o_P_MByteEn = '0;
    o_M_SCmdAccept = '0;
    o_M_SData = '0;
    o_M_SResp = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (grant_q[k] && !rst) begin
        if (state_q == S_CMD && !expire) begin
          o_P_MAddr = i_M_MAddr[k*ADDR_WIDTH +: ADDR_WIDTH];
          o_P_MCmd = i_M_MCmd[k*3 +: 3];
          o_P_MData = i_M_MData[k*DATA_WIDTH +: DATA_WIDTH];
          o_P_MByteEn = i_M_MByteEn[k*BEN_WIDTH +: BEN_WIDTH];
        end
        o_M_SCmdAccept[k] = state_q == S_CMD && (i_P_SCmdAccept || expire);
        o_M_SResp[k*2 +: 2] = expire ? SRESP_ERR : state_q == S_RESP ? i_P_SResp : SRESP_NULL;
        o_M_SData[k*DATA_WIDTH +: DATA_WIDTH] = (state_q == S_RESP && !expire) ? i_P_SData : '0;
      end
    end
  end
  assign o_grant = rst ? '0 : grant_q;
  assign o_timeout = expire && !rst;
endmodule

// File: tb/tb_fabric_port_arbiter.sv
// tb_fabric_port_arbiter: directed vector table plus hand sequences for the 3-port arbiter
module tb_fabric_port_arbiter;
  import fabric_port_arbiter_pkg::*;
  localparam int N = 3;
`ifdef FABRIC_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  localparam int STALL = 2;
`else
  localparam bit TMO_EN = 1'b0;
  localparam int STALL = 5;
`endif
  localparam logic [8:0] ALL_RD = {MCMD_RD, MCMD_RD, MCMD_RD};
  localparam logic [8:0] M0_RD = {MCMD_IDLE, MCMD_IDLE, MCMD_RD};
  localparam logic [8:0] M1_RD = {MCMD_IDLE, MCMD_RD, MCMD_IDLE};
  localparam logic [8:0] M1_WR = {MCMD_IDLE, MCMD_WR, MCMD_IDLE};
  localparam logic [8:0] M2_RD = {MCMD_RD, MCMD_IDLE, MCMD_IDLE};
  localparam logic [1:0] NL = SRESP_NULL;
  localparam logic [1:0] DV = SRESP_DVA;
  logic clk = 1'b0;
  logic rst;
  logic [N*32-1:0] maddr, mdata, msd;
  logic [N*3-1:0] mcmd;
  logic [N*4-1:0] mben;
  logic [N-1:0] macc, grant;
  logic [N*2-1:0] mresp;
  logic [31:0] paddr, pdata, psd;
  logic [2:0] pcmd;
  logic [3:0] pben;
  logic [1:0] presp;
  logic pacc, tmo;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  fabric_port_arbiter #(.NPORTS(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BEN_WIDTH(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_M_MAddr(maddr), .i_M_MCmd(mcmd), .i_M_MData(mdata), .i_M_MByteEn(mben),
    .o_M_SCmdAccept(macc), .o_M_SData(msd), .o_M_SResp(mresp),
    .o_P_MAddr(paddr), .o_P_MCmd(pcmd), .o_P_MData(pdata), .o_P_MByteEn(pben),
    .i_P_SCmdAccept(pacc), .i_P_SData(psd), .i_P_SResp(presp),
    .o_grant(grant), .o_timeout(tmo)
  );
  typedef struct {
    logic rst;
    logic [8:0] mcmd;
    logic acc;
    logic [1:0] resp;
    logic [31:0] sd;
    logic [2:0] g;
    logic [2:0] pcmd;
    logic [31:0] paddr;
    logic [2:0] macc;
    logic [5:0] mresp;
    logic [95:0] msd;
  } vec_t;
  vec_t vt[20];
  function automatic vec_t mk(input logic r, input logic [8:0] c, input logic a, input logic [1:0] rs,
                              input logic [31:0] s, input logic [2:0] g, input logic [2:0] pc,
                              input logic [31:0] pa, input logic [2:0] ma, input logic [5:0] mr,
                              input logic [95:0] md);
    vec_t v;
    v.rst = r; v.mcmd = c; v.acc = a; v.resp = rs; v.sd = s;
    v.g = g; v.pcmd = pc; v.paddr = pa; v.macc = ma; v.mresp = mr; v.msd = md;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [8:0] c, input logic a, input logic [1:0] r, input logic [31:0] s);
    mcmd = c; pacc = a; presp = r; psd = s;
    #1;
  endtask
  initial begin
    maddr = {32'h3000, 32'h2000, 32'h1000};
    mdata = {32'hA2, 32'hA1, 32'hA0};
    mben = {4'hC, 4'h3, 4'hF};
    rst = 1'b1; mcmd = '0; pacc = 1'b0; presp = NL; psd = '0;
    vt[0]  = mk(1, 0, 0, NL, 0, 0, MCMD_IDLE, 0, 0, 0, 0);
    vt[1]  = mk(0, M0_RD, 0, NL, 0, 0, MCMD_IDLE, 0, 0, 0, 0);
    vt[2]  = mk(0, M0_RD, 1, NL, 0, 3'b001, MCMD_RD, 32'h1000, 3'b001, 0, 0);
    vt[3]  = mk(0, 0, 0, NL, 0, 3'b001, MCMD_IDLE, 0, 0, 0, 0);
    vt[4]  = mk(0, 0, 0, DV, 32'hDEADBEEF, 3'b001, MCMD_IDLE, 0, 0, 6'b000001, {64'h0, 32'hDEADBEEF});
    vt[5]  = mk(0, 0, 0, NL, 32'hDEADBEEF, 0, MCMD_IDLE, 0, 0, 0, 0);
    vt[6]  = mk(1, ALL_RD, 1, DV, 32'h33, 0, MCMD_IDLE, 0, 0, 0, 0);
    vt[7]  = mk(0, ALL_RD, 1, DV, 32'h33, 0, MCMD_IDLE, 0, 0, 0, 0);
    vt[8]  = mk(0, ALL_RD, 1, DV, 32'h33, 3'b001, MCMD_RD, 32'h1000, 3'b001, 0, 0);
    vt[9]  = mk(0, ALL_RD, 1, DV, 32'h33, 3'b001, MCMD_IDLE, 0, 0, 6'b000001, {64'h0, 32'h33});
    vt[10] = mk(0, ALL_RD, 1, DV, 32'h33, 0, MCMD_IDLE, 0, 0, 0, 0);
    vt[11] = mk(0, ALL_RD, 1, DV, 32'h33, 3'b010, MCMD_RD, 32'h2000, 3'b010, 0, 0);
    vt[12] = mk(0, ALL_RD, 1, DV, 32'h33, 3'b010, MCMD_IDLE, 0, 0, 6'b000100, {32'h0, 32'h33, 32'h0});
    vt[13] = mk(0, ALL_RD, 1, DV, 32'h33, 0, MCMD_IDLE, 0, 0, 0, 0);
    vt[14] = mk(0, ALL_RD, 1, DV, 32'h33, 3'b100, MCMD_RD, 32'h3000, 3'b100, 0, 0);
    vt[15] = mk(0, ALL_RD, 1, DV, 32'h33, 3'b100, MCMD_IDLE, 0, 0, 6'b010000, {32'h33, 64'h0});
    vt[16] = mk(0, ALL_RD, 1, DV, 32'h33, 0, MCMD_IDLE, 0, 0, 0, 0);
    vt[17] = mk(0, ALL_RD, 1, DV, 32'h33, 3'b001, MCMD_RD, 32'h1000, 3'b001, 0, 0);
    vt[18] = mk(0, 0, 0, DV, 32'h33, 3'b001, MCMD_IDLE, 0, 0, 6'b000001, {64'h0, 32'h33});
    vt[19] = mk(0, 0, 0, NL, 0, 0, MCMD_IDLE, 0, 0, 0, 0);
    tick;
    for (int i = 0; i < 20; i++) begin
      rst = vt[i].rst;
      drive(vt[i].mcmd, vt[i].acc, vt[i].resp, vt[i].sd);
      chk($sformatf("v%0d_grant", i), grant, vt[i].g);
      chk($sformatf("v%0d_pcmd", i), pcmd, vt[i].pcmd);
      chk($sformatf("v%0d_paddr", i), paddr, vt[i].paddr);
      chk($sformatf("v%0d_macc", i), macc, vt[i].macc);
      chk($sformatf("v%0d_mresp", i), mresp, vt[i].mresp);
      chk($sformatf("v%0d_msd", i), msd, vt[i].msd);
      tick;
    end
    drive(M0_RD, 0, NL, 0); tick;
    drive(M0_RD, 1, NL, 0); chk("a_grant0", grant, 3'b001); tick;
    for (int i = 0; i < 2; i++) begin
      drive(M1_WR, 1, NL, 0);
      chk("a_m1_stall", macc, 0);
      chk("a_pcmd_resp", pcmd, MCMD_IDLE);
      tick;
    end
    drive(M1_WR, 1, DV, 32'h44);
    chk("a_m1_stall_resp", macc, 0);
    chk("a_m0_resp", mresp, 6'b000001);
    chk("a_m0_data", msd, {64'h0, 32'h44});
    tick;
    drive(M1_WR, 1, NL, 0);
    chk("a_idle_pcmd", pcmd, MCMD_IDLE);
    chk("a_idle_grant", grant, 0);
    tick;
    drive(M1_WR, 1, NL, 0);
    chk("a_m1_grant", grant, 3'b010);
    chk("a_m1_pcmd", pcmd, MCMD_WR);
    chk("a_m1_paddr", paddr, 32'h2000);
    chk("a_m1_pdata", pdata, 32'hA1);
    chk("a_m1_pben", pben, 4'h3);
    chk("a_m1_acc", macc, 3'b010);
    tick;
    drive(0, 0, DV, 32'h45);
    chk("a_m1_resp", mresp, 6'b000100);
    chk("a_m1_data", msd, {32'h0, 32'h45, 32'h0});
    tick;
    drive(M2_RD, 0, NL, 0); tick;
    for (int i = 0; i < STALL; i++) begin
      drive(M2_RD, 0, NL, 0);
      chk("b_stall_pcmd", pcmd, MCMD_RD);
      chk("b_stall_paddr", paddr, 32'h3000);
      chk("b_stall_acc", macc, 0);
      tick;
    end
    drive(M2_RD, 1, NL, 0); chk("b_acc", macc, 3'b100); chk("b_pben", pben, 4'hC); tick;
    drive(0, 0, DV, 32'h55); chk("b_resp", mresp, 6'b010000); tick;
    drive(M1_RD, 0, NL, 0); tick;
    drive(M1_RD, 1, NL, 0); chk("c_grant1", grant, 3'b010); tick;
    rst = 1'b1;
    drive(ALL_RD, 0, DV, 32'h66);
    chk("c_rst_resp", mresp, 0);
    chk("c_rst_grant", grant, 0);
    tick;
    rst = 1'b0;
    drive(ALL_RD, 0, DV, 32'h66);
    chk("c_after_grant", grant, 0);
    chk("c_after_pcmd", pcmd, MCMD_IDLE);
    chk("c_after_resp", mresp, 0);
    tick;
    drive(ALL_RD, 1, NL, 0); chk("c_m0_first", grant, 3'b001); tick;
    drive(0, 0, DV, 32'h67); chk("c_m0_resp", mresp, 6'b000001); tick;
    drive(M0_RD, 0, NL, 0); tick;
    drive(M0_RD, 1, NL, 0); chk("d_cmd_tmo", tmo, 0); tick;
    for (int i = 1; i <= 4; i++) begin
      logic exp_err;
      exp_err = TMO_EN && i == 4;
      drive(0, 0, NL, 32'h77);
      chk($sformatf("d_resp%0d", i), mresp, exp_err ? 6'b000011 : 6'b000000);
      chk($sformatf("d_tmo%0d", i), tmo, exp_err);
      chk($sformatf("d_grant%0d", i), grant, 3'b001);
      if (exp_err) chk("d_err_data", msd, 0);
      tick;
    end
    drive(0, 0, DV, 32'h78);
    chk("d_after_grant", grant, TMO_EN ? 3'b000 : 3'b001);
    chk("d_late_resp", mresp, TMO_EN ? 6'b000000 : 6'b000001);
    tick;
    drive(0, 0, NL, 0); chk("d_final_grant", grant, 0); tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
